ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Programming-side controller that sequences one configuration-chain segment, such as a connection-block ccff_head→ccff_tail chain of mux SRAM flops.
- Accepts bitstream words over a valid/ready stream, serialises them MSB-first into ccff_head and issues a per-cycle shift enable for the chain's prog_clk gating.
- Optionally runs a non-destructive readback: the chain is recirculated once and a CRC-8 of the bits shifted in is compared against a CRC-8 of the bits shifted out.
- One instance per chain segment; it sits between the bitstream fetch logic and the tile's ccff_head/ccff_tail pins.

Parameters:
- WORD_W, 8, width of the input bitstream word.
- CHAIN_LEN, 58, number of flops in the chain. 58 = 9 muxes × 6 SRAM bits + 2 muxes × 2 SRAM bits.
- CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk, in, 1, programming clock; the only clock.
- pReset, in, 1, synchronous, active-high reset.
- cfg_start, in, 1, one-cycle start request; honoured only in IDLE.
- cfg_verify, in, 1, sampled together with cfg_start; 1 = run the VERIFY pass after LOAD.
- cfg_abort, in, 1, returns the block to IDLE from any state.
- cfg_data, in, WORD_W, bitstream word; bit WORD_W-1 is shifted first.
- cfg_valid, in, 1, cfg_data is valid.
- cfg_ready, out, 1, block accepts cfg_data this cycle.
- ccff_head, out, 1, serial data into the chain.
- ccff_shift_en, out, 1, the chain advances one bit on this prog_clk edge.
- ccff_tail, in, 1, serial data out of the last chain flop.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse on completion.
- crc_err, out, 1, sticky verify mismatch; cleared by the next accepted cfg_start.
- aborted, out, 1, sticky abort flag; cleared by the next accepted cfg_start.

Behaviour:
- Reset (pReset=1 at a prog_clk edge):
  - state←IDLE; all counters, shift buffer and both CRCs←0.
  - cfg_ready, ccff_head, ccff_shift_en, busy, done, crc_err and aborted all←0.
  - Reset mid-operation abandons the chain contents; no done pulse.
- States: IDLE, LOAD, VERIFY, FIN.
- IDLE:
  - On cfg_start: latch cfg_verify, clear bit_cnt, crc_in, crc_out, crc_err and aborted, then go to LOAD.
  - cfg_start while busy is ignored.
- LOAD, word handling:
  - A WORD_W shift buffer holds buf_cnt remaining bits.
  - cfg_ready = (state==LOAD) && (buf_cnt==0) && (bit_cnt<CHAIN_LEN).
  - On cfg_valid && cfg_ready: buffer←cfg_data, buf_cnt←WORD_W. No shift happens in the accept cycle.
- LOAD, shifting:
  - Each cycle with buf_cnt>0 and bit_cnt<CHAIN_LEN: ccff_head=buffer MSB, ccff_shift_en=1, buffer shifts left, buf_cnt−1, bit_cnt+1.
  - crc_in updates with ccff_head using CRC-8, polynomial x^8+x^2+x+1, init 0x00, MSB-first, no reflection, no final XOR.
  - Buffer empty and no valid word: ccff_shift_en=0 and the chain holds (stall of any length is legal).
- LOAD completion:
  - The cycle bit_cnt reaches CHAIN_LEN: discard leftover buffer bits (buf_cnt←0) and clear bit_cnt.
  - Next state is VERIFY if verify was latched, else FIN.
  - Words required = ceil(CHAIN_LEN/WORD_W). The low bits of the final word are padding.
- VERIFY:
  - Runs exactly CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail (recirculation), so chain contents are unchanged at the end.
  - Each cycle, crc_out updates with ccff_tail.
  - After CHAIN_LEN cycles go to FIN; crc_err←(crc_out_final≠crc_in).
- FIN: done=1 for exactly one cycle, then IDLE.
- cfg_abort:
  - Takes priority over every other event in the same cycle, including a completion or cfg_start.
  - In a non-IDLE state: state←IDLE, aborted←1, ccff_shift_en←0, buffer dropped, no done pulse.
  - In IDLE it is a no-op.
- Registered outputs: ccff_head and ccff_shift_en come from registered state and buffer; no combinational path from cfg_valid.
- Latency:
  - With back-to-back valid words, LOAD takes CHAIN_LEN shift cycles plus ceil(CHAIN_LEN/WORD_W) accept cycles.
  - VERIFY takes CHAIN_LEN cycles; FIN takes 1 cycle.

Decomposition:
- Package ccff_loader_pkg:
  - state enum (IDLE, LOAD, VERIFY, FIN);
  - CRC8_POLY=8'h07;
  - function crc8_step(crc, bit).
- One sub-module, ccff_crc8_ser: serial CRC-8 with clear, enable and data bit. Instantiated twice (crc_in, crc_out).

Test Plan:
- Load without verify (CHAIN_LEN=58, WORD_W=8), 8 words with cfg_valid held high:
  - exactly 8 handshakes and 58 ccff_shift_en cycles;
  - a behavioural 58-flop chain model holds the first 58 MSB-first bits;
  - done pulses once; crc_err=0.
- Load plus verify on an ideal chain model: 58 further shift cycles; chain contents unchanged; crc_err=0; done pulses once.
- Fault injection: chain model with bit 20 stuck-at-1 and a bitstream bit 20 of 0 → crc_err=1 after verify; crc_err remains 1 until the next cfg_start.
- Stalls: cfg_valid gated 1-in-4 → ccff_shift_en=0 whenever the buffer is empty; final chain contents are identical to the first scenario.
- Abort at word 3 of LOAD, then cfg_start plus reset in the same cycle → aborted=1, no done; all outputs 0 after the reset edge, state IDLE.
- cfg_start pulsed during VERIFY → ignored; exactly one done pulse.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-8 helper for the configuration-chain loader.
package ccff_loader_pkg;

   typedef enum logic [1:0] {StIdle, StLoad, StVerify, StFin} state_e;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // One MSB-first CRC-8 step: x^8+x^2+x+1, no reflection.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/ccff_crc8_ser.sv
// Serial CRC-8 accumulator with synchronous clear and per-bit enable.
module ccff_crc8_ser
   import ccff_loader_pkg::*;
(
   input  logic       prog_clk,
   input  logic       pReset,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [7:0] crc
);

   logic [7:0] crc_q;

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         crc_q <= 8'h00;
      end else if (clr) begin
         crc_q <= 8'h00;
      end else if (en) begin
         crc_q <= crc8_step(crc_q, din);
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads one ccff_head->ccff_tail configuration chain from a word stream and optionally
// verifies it by recirculating the chain once and comparing CRCs of bits in and out.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CHAIN_LEN = 58,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              cfg_start,
   input  logic              cfg_verify,
   input  logic              cfg_abort,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              crc_err,
   output logic              aborted
);

   localparam int unsigned     BCW       = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] ChainLen = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LastBit  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [BCW-1:0]   WordBits = BCW'(WORD_W);

   state_e            state_q, state_d;
   logic              verify_q, verify_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] buf_q, buf_d;
   logic [BCW-1:0]    buf_cnt_q, buf_cnt_d;
   logic              crc_err_q, crc_err_d;
   logic              aborted_q, aborted_d;

   logic       load_shift, last_bit, start_acc;
   logic       crc_in_en, crc_out_en;
   logic [7:0] crc_in, crc_out;

   assign load_shift = (state_q == StLoad) && (buf_cnt_q != '0) && (bit_cnt_q < ChainLen);
   assign last_bit   = (bit_cnt_q == LastBit);
   assign start_acc  = (state_q == StIdle) && cfg_start && !cfg_abort;

   assign cfg_ready     = (state_q == StLoad) && (buf_cnt_q == '0) && (bit_cnt_q < ChainLen);
   // Abort must stop the chain in the very cycle it is raised.
   assign ccff_shift_en = (load_shift || (state_q == StVerify)) && !cfg_abort;
   assign ccff_head     = load_shift ? buf_q[WORD_W-1] :
                          (state_q == StVerify) ? ccff_tail : 1'b0;
   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StFin) && !cfg_abort;
   assign crc_err       = crc_err_q;
   assign aborted       = aborted_q;

   assign crc_in_en  = ccff_shift_en && (state_q == StLoad);
   assign crc_out_en = ccff_shift_en && (state_q == StVerify);

   always_comb begin
      state_d   = state_q;
      verify_d  = verify_q;
      bit_cnt_d = bit_cnt_q;
      buf_d     = buf_q;
      buf_cnt_d = buf_cnt_q;
      crc_err_d = crc_err_q;
      aborted_d = aborted_q;
      if (cfg_abort) begin
         if (state_q != StIdle) begin
            state_d   = StIdle;
            aborted_d = 1'b1;
            buf_d     = '0;
            buf_cnt_d = '0;
            bit_cnt_d = '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cfg_start) begin
                  verify_d  = cfg_verify;
                  bit_cnt_d = '0;
                  crc_err_d = 1'b0;
                  aborted_d = 1'b0;
                  state_d   = StLoad;
               end
            end
            StLoad: begin
               if (load_shift) begin
                  buf_d     = buf_q << 1;
                  buf_cnt_d = buf_cnt_q - BCW'(1);
                  if (last_bit) begin
                     // Remaining bits of the final word are padding.
                     buf_d     = '0;
                     buf_cnt_d = '0;
                     bit_cnt_d = '0;
                     state_d   = verify_q ? StVerify : StFin;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end else if (cfg_valid && cfg_ready) begin
                  buf_d     = cfg_data;
                  buf_cnt_d = WordBits;
               end
            end
            StVerify: begin
               if (last_bit) begin
                  bit_cnt_d = '0;
                  crc_err_d = (crc8_step(crc_out, ccff_tail) != crc_in);
                  state_d   = StFin;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q   <= StIdle;
         verify_q  <= 1'b0;
         bit_cnt_q <= '0;
         buf_q     <= '0;
         buf_cnt_q <= '0;
         crc_err_q <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         verify_q  <= verify_d;
         bit_cnt_q <= bit_cnt_d;
         buf_q     <= buf_d;
         buf_cnt_q <= buf_cnt_d;
         crc_err_q <= crc_err_d;
         aborted_q <= aborted_d;
      end
   end

   ccff_crc8_ser u_crc_in (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .clr      (start_acc),
      .en       (crc_in_en),
      .din      (ccff_head),
      .crc      (crc_in)
   );

   ccff_crc8_ser u_crc_out (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .clr      (start_acc),
      .en       (crc_out_en),
      .din      (ccff_tail),
      .crc      (crc_out)
   );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 58-flop chain model driven by the DUT, random words,
// and expectations built from the bitstream and polynomial long division.
module tb_ccff_chain_loader;

   localparam int WORD_W    = 8;
   localparam int CHAIN_LEN = 58;
   localparam int CNT_W     = 16;
   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

   logic              prog_clk = 1'b0;
   logic              pReset = 1'b1;
   logic              cfg_start = 1'b0, cfg_verify = 1'b0, cfg_abort = 1'b0;
   logic [WORD_W-1:0] cfg_data = '0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
   logic              busy, done, crc_err, aborted;

   ccff_chain_loader #(
      .WORD_W    (WORD_W),
      .CHAIN_LEN (CHAIN_LEN),
      .CNT_W     (CNT_W)
   ) dut (
      .prog_clk      (prog_clk),
      .pReset        (pReset),
      .cfg_start     (cfg_start),
      .cfg_verify    (cfg_verify),
      .cfg_abort     (cfg_abort),
      .cfg_data      (cfg_data),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .busy          (busy),
      .done          (done),
      .crc_err       (crc_err),
      .aborted       (aborted)
   );

   always #5 prog_clk = ~prog_clk;

   // Chain model: chain[0] is the first flop, chain[CHAIN_LEN-1] drives ccff_tail.
   logic [CHAIN_LEN-1:0] chain = '0;
   logic [CHAIN_LEN-1:0] chain_nx;
   logic                 stuck = 1'b0;
   logic                 se_s = 1'b0, hd_s = 1'b0;

   assign ccff_tail = chain[CHAIN_LEN-1];

   always begin
      @(negedge prog_clk);
      #3;
      se_s = ccff_shift_en;
      hd_s = ccff_head;
   end

   always @(posedge prog_clk) begin
      chain_nx = chain;
      if (se_s) chain_nx = {chain[CHAIN_LEN-2:0], hd_s};
      if (stuck) chain_nx[20] = 1'b1;
      chain <= chain_nx;
   end

   int                   n_cmp = 0;
   int                   n_err = 0;
   logic [WORD_W-1:0]    words[NWORDS];
   logic [WORD_W-1:0]    first_words[NWORDS];
   logic [CHAIN_LEN-1:0] exp_chain, first_chain;
   bit                   in_bits[$];
   bit                   out_bits[$];

   int r_hs, r_shifts, r_dones, r_busy, r_viol;
   bit r_to;

   // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1.
   function automatic logic [7:0] crc_ref(input bit m[$]);
      logic [8:0] rem;
      bit         b;
      rem = '0;
      for (int i = 0; i < m.size() + 8; i++) begin
         b   = (i < m.size()) ? m[i] : 1'b0;
         rem = {rem[7:0], b};
         if (rem[8]) rem = rem ^ 9'h107;
      end
      return rem[7:0];
   endfunction

   task automatic build_bits(input bit randomize_words, input bit force_flop20_zero);
      if (randomize_words)
         for (int w = 0; w < NWORDS; w++) words[w] = WORD_W'($urandom_range(0, 255));
      // Stream bit 37 ends up in flop 20 (bit i lands in flop CHAIN_LEN-1-i).
      if (force_flop20_zero) words[4][2] = 1'b0;
      in_bits.delete();
      for (int i = 0; i < CHAIN_LEN; i++) in_bits.push_back(words[i / WORD_W][WORD_W - 1 - (i % WORD_W)]);
      for (int i = 0; i < CHAIN_LEN; i++) exp_chain[CHAIN_LEN - 1 - i] = in_bits[i];
   endtask

   task automatic drive_run(input bit verify, input int gate_n, input int abort_word,
                            input bit extra_start);
      int  widx;
      int  cyc;
      bit  gate;
      r_hs = 0; r_shifts = 0; r_dones = 0; r_busy = 0; r_viol = 0; r_to = 0;
      out_bits.delete();
      @(negedge prog_clk);
      cfg_start = 1'b1; cfg_verify = verify; cfg_valid = 1'b0;
      @(negedge prog_clk);
      cfg_start = 1'b0; cfg_verify = 1'b0;
      widx = 0; cyc = 0;
      while (1) begin
         gate       = (gate_n <= 1) || ($urandom_range(0, gate_n - 1) == 0);
         cfg_abort  = (abort_word >= 0) && (widx == abort_word);
         cfg_valid  = (widx < NWORDS) && gate && !cfg_abort;
         cfg_data   = (widx < NWORDS) ? words[widx] : '0;
         cfg_start  = extra_start && (r_shifts == 70);
         #1;
         if (busy) r_busy++;
         if (cfg_ready && ccff_shift_en) r_viol++;
         if (cfg_valid && cfg_ready) begin
            r_hs++;
            widx++;
         end
         if (ccff_shift_en) begin
            if (r_shifts >= CHAIN_LEN) out_bits.push_back(ccff_tail);
            r_shifts++;
         end
         if (done) r_dones++;
         if (done || cfg_abort) break;
         cyc++;
         if (cyc > 1000) begin
            r_to = 1'b1;
            break;
         end
         @(negedge prog_clk);
      end
      @(negedge prog_clk);
      cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_start = 1'b0;
      repeat (4) begin
         #1;
         if (done) r_dones++;
         @(negedge prog_clk);
      end
   endtask

   task automatic test_reset();
      logic [6:0] obs;
      pReset = 1'b1;
      repeat (3) @(negedge prog_clk);
      #1;
      obs = {cfg_ready, ccff_head, ccff_shift_en, busy, done, crc_err, aborted};
      n_cmp++;
      if (obs !== 7'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b want 0000000", obs);
      end
      @(negedge prog_clk);
      pReset = 1'b0;
   endtask

   task automatic test_load_no_verify();
      build_bits(1'b1, 1'b0);
      first_words = words;
      first_chain = exp_chain;
      drive_run(1'b0, 1, -1, 1'b0);
      n_cmp++; if (r_to !== 1'b0) begin n_err++; $display("FAIL load_timeout: got %0d want 0", r_to); end
      n_cmp++; if (r_hs != NWORDS) begin n_err++; $display("FAIL load_handshakes: got %0d want %0d", r_hs, NWORDS); end
      n_cmp++; if (r_shifts != CHAIN_LEN) begin n_err++; $display("FAIL load_shifts: got %0d want %0d", r_shifts, CHAIN_LEN); end
      n_cmp++; if (r_dones != 1) begin n_err++; $display("FAIL load_done_count: got %0d want 1", r_dones); end
      n_cmp++;
      if (r_busy != CHAIN_LEN + NWORDS + 1) begin
         n_err++;
         $display("FAIL load_latency: got %0d want %0d", r_busy, CHAIN_LEN + NWORDS + 1);
      end
      n_cmp++; if (chain !== exp_chain) begin n_err++; $display("FAIL load_chain: got %h want %h", chain, exp_chain); end
      n_cmp++; if (crc_err !== 1'b0) begin n_err++; $display("FAIL load_crc_err: got %b want 0", crc_err); end
   endtask

   task automatic test_load_verify();
      build_bits(1'b1, 1'b0);
      drive_run(1'b1, 1, -1, 1'b0);
      n_cmp++; if (r_to !== 1'b0) begin n_err++; $display("FAIL verify_timeout: got %0d want 0", r_to); end
      n_cmp++; if (r_shifts != 2 * CHAIN_LEN) begin n_err++; $display("FAIL verify_shifts: got %0d want %0d", r_shifts, 2 * CHAIN_LEN); end
      n_cmp++; if (r_dones != 1) begin n_err++; $display("FAIL verify_done_count: got %0d want 1", r_dones); end
      n_cmp++;
      if (r_busy != 2 * CHAIN_LEN + NWORDS + 1) begin
         n_err++;
         $display("FAIL verify_latency: got %0d want %0d", r_busy, 2 * CHAIN_LEN + NWORDS + 1);
      end
      n_cmp++; if (chain !== exp_chain) begin n_err++; $display("FAIL verify_chain: got %h want %h", chain, exp_chain); end
      n_cmp++; if (crc_err !== 1'b0) begin n_err++; $display("FAIL verify_crc_err: got %b want 0", crc_err); end
   endtask

   task automatic test_fault();
      logic exp_err;
      stuck = 1'b1;
      build_bits(1'b1, 1'b1);
      drive_run(1'b1, 1, -1, 1'b0);
      exp_err = (crc_ref(in_bits) != crc_ref(out_bits));
      n_cmp++; if (r_dones != 1) begin n_err++; $display("FAIL fault_done_count: got %0d want 1", r_dones); end
      n_cmp++; if (crc_err !== exp_err) begin n_err++; $display("FAIL fault_crc_err: got %b want %b", crc_err, exp_err); end
      repeat (3) @(negedge prog_clk);
      #1;
      n_cmp++; if (crc_err !== 1'b1) begin n_err++; $display("FAIL fault_crc_err_sticky: got %b want 1", crc_err); end
      @(negedge prog_clk);
      cfg_start = 1'b1;
      @(negedge prog_clk);
      cfg_start = 1'b0;
      #1;
      n_cmp++; if (crc_err !== 1'b0) begin n_err++; $display("FAIL fault_crc_err_clear: got %b want 0", crc_err); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fault_restart_busy: got %b want 1", busy); end
      cfg_abort = 1'b1;
      @(negedge prog_clk);
      cfg_abort = 1'b0;
      stuck = 1'b0;
   endtask

   task automatic test_stalls();
      words = first_words;
      build_bits(1'b0, 1'b0);
      drive_run(1'b0, 4, -1, 1'b0);
      n_cmp++; if (r_to !== 1'b0) begin n_err++; $display("FAIL stall_timeout: got %0d want 0", r_to); end
      n_cmp++; if (r_hs != NWORDS) begin n_err++; $display("FAIL stall_handshakes: got %0d want %0d", r_hs, NWORDS); end
      n_cmp++; if (r_shifts != CHAIN_LEN) begin n_err++; $display("FAIL stall_shifts: got %0d want %0d", r_shifts, CHAIN_LEN); end
      n_cmp++; if (r_viol != 0) begin n_err++; $display("FAIL stall_shift_while_empty: got %0d want 0", r_viol); end
      n_cmp++; if (r_dones != 1) begin n_err++; $display("FAIL stall_done_count: got %0d want 1", r_dones); end
      n_cmp++; if (chain !== first_chain) begin n_err++; $display("FAIL stall_chain: got %h want %h", chain, first_chain); end
      n_cmp++; if (aborted !== 1'b0) begin n_err++; $display("FAIL stall_aborted_cleared: got %b want 0", aborted); end
   endtask

   task automatic test_abort_reset();
      logic [6:0] obs;
      build_bits(1'b1, 1'b0);
      drive_run(1'b0, 1, 3, 1'b0);
      n_cmp++; if (r_hs != 3) begin n_err++; $display("FAIL abort_handshakes: got %0d want 3", r_hs); end
      n_cmp++; if (r_dones != 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", r_dones); end
      n_cmp++; if (aborted !== 1'b1) begin n_err++; $display("FAIL abort_flag: got %b want 1", aborted); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle: got %b want 0", busy); end
      cfg_start = 1'b1;
      pReset    = 1'b1;
      @(negedge prog_clk);
      cfg_start = 1'b0;
      pReset    = 1'b0;
      #1;
      obs = {cfg_ready, ccff_head, ccff_shift_en, busy, done, crc_err, aborted};
      n_cmp++;
      if (obs !== 7'b0) begin
         n_err++;
         $display("FAIL start_with_reset_outputs: got %b want 0000000", obs);
      end
   endtask

   task automatic test_start_during_verify();
      build_bits(1'b1, 1'b0);
      drive_run(1'b1, 1, -1, 1'b1);
      n_cmp++; if (r_dones != 1) begin n_err++; $display("FAIL busy_start_done_count: got %0d want 1", r_dones); end
      n_cmp++;
      if (r_busy != 2 * CHAIN_LEN + NWORDS + 1) begin
         n_err++;
         $display("FAIL busy_start_latency: got %0d want %0d", r_busy, 2 * CHAIN_LEN + NWORDS + 1);
      end
      n_cmp++; if (chain !== exp_chain) begin n_err++; $display("FAIL busy_start_chain: got %h want %h", chain, exp_chain); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_idle: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_load_no_verify();
      test_load_verify();
      test_fault();
      test_stalls();
      test_abort_reset();
      test_start_during_verify();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
